writeback_rob: RTL and testbench
================================

# writeback_rob

In-order completion buffer sitting directly upstream of the commit stage. It allocates one entry per issued instruction and accepts out-of-order execution results by tag. It retires entries strictly in program order onto the commit stage's register-file write port (`commit_regfile_we/waddr/wdata`) under the commit stage's `commit_ack` handshake. A flush discards all in-flight entries on branch mispredict.

## Interface
- `DEPTH`, 8: number of entries; power of two, at least 2.
- `TAG_W`, `$clog2(DEPTH)`: entry tag width.
- `REG_ADDR_SIZE`, 5: architectural register address width.
- `REG_DATA_WIDTH`, 32: register data width.

- `clk_i` in 1: single clock; everything is on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `alloc_valid_i` in 1: issue requests an entry.
- `alloc_ready_o` out 1: an entry is free.
- `alloc_we_i` in 1: the instruction writes a register.
- `alloc_waddr_i` in REG_ADDR_SIZE: destination register.
- `alloc_tag_o` out TAG_W: tag assigned to this cycle's allocation (the tail index).
- `wb_valid_i` in 1: an execution unit reports a result.
- `wb_tag_i` in TAG_W: entry being completed.
- `wb_data_i` in REG_DATA_WIDTH: result data.
- `commit_ack_i` in 1: commit stage accepts the head this cycle.
- `commit_regfile_we_o` out 1: register write strobe to commit.
- `commit_regfile_waddr_o` out REG_ADDR_SIZE: register write address.
- `commit_regfile_wdata_o` out REG_DATA_WIDTH: register write data.
- `flush_i` in 1: discard all entries.
- `empty_o` out 1: no valid entries.
- `count_o` out TAG_W+1: number of valid entries.

## Operation
- **Storage.** An entry array with fields `valid`, `done`, `we`, `waddr`, `data`.
- **Pointers.** `head` and `tail` are TAG_W+1 bits wide; the MSB is the wrap bit.
  - Full when the index bits are equal and the MSBs differ.
  - Empty when the pointers are equal.
- **Allocate.** An allocation fires when `alloc_valid_i && alloc_ready_o`.
  - Writes `entry[tail] = {valid=1, done=0, we, waddr}` and increments `tail`.
  - `alloc_tag_o` always shows `tail[TAG_W-1:0]`.
- **Writeback.** When `wb_valid_i` is high and `entry[wb_tag_i].valid` is set, the block sets `done=1` and stores `data`.
  - A writeback to an invalid entry is ignored.
  - A writeback to an entry that is already done overwrites its data. A correct upstream never does this.
- **Retire.** `retire = entry[head].valid && entry[head].done && commit_ack_i && !flush_i`.
  - On retire, the entry's `valid` clears and `head` increments.
  - Entries with `we=0` retire silently.
- **Commit outputs** are combinational from head state:
  - `commit_regfile_we_o = retire && head.we`.
  - `commit_regfile_waddr_o` is the head's waddr and `commit_regfile_wdata_o` is the head's data. Both read zero when the head is not valid.
- **`alloc_ready_o = !full`.** It does not credit a same-cycle retire.
- **Flush.** `flush_i` clears every `valid`, sets `head=tail=0` at the next edge, and blocks allocate, writeback and retire in that cycle.
- **`count_o = tail - head`**, computed with modulo 2^(TAG_W+1) arithmetic. `empty_o = (count_o == 0)`.

## Timing
- **Reset values** (rst_i high at an edge): all `valid=0`, `head=tail=0`. Outputs are then:
  - `alloc_ready_o=1`, `alloc_tag_o=0`, `empty_o=1`, `count_o=0`;
  - `commit_regfile_we_o=0`, `commit_regfile_waddr_o=0`, `commit_regfile_wdata_o=0`.
- **Latencies:**
  - An allocation at edge N is visible from cycle N+1.
  - A writeback in cycle N sets `done` at edge N; the earliest retire is cycle N+1. There is no writeback-to-commit bypass.
  - Retire throughput is one per cycle.
- **Simultaneous events:**
  - Allocate and retire in the same cycle leave `count` unchanged.
  - Writeback to the head tag and retire of that same head cannot happen in one cycle, because `done` is not yet set.
  - A writeback and an allocation to the same index cannot collide, since an allocated index is never valid.
- **Full:** `alloc_ready_o=0`; `alloc_valid_i` is ignored and the tail does not move.
- **Empty:** no retire; commit outputs are zero.
- **Wrap-around:** pointers wrap naturally. After 2·DEPTH allocations, `tail` equals its reset value.
- **Precedence:** reset over flush, and flush over everything else.
- **Reset or flush mid-stream:** in-flight entries are lost and no commit write is emitted in that cycle.
- **Ack:** `commit_ack_i` low holds the head indefinitely and the outputs stay stable.

## Structure
- Shared package (alongside the existing `REG_ADDR_SIZE` / `REG_DATA_WIDTH` definitions):
  - `rob_entry_t` packed struct `{valid, done, we, waddr, data}`;
  - `rob_tag_t` typedef.
- A single module with no sub-module: the entry array, two pointers and combinational head decode.
- Issue keeps `alloc_tag_o` with the instruction and returns it on `wb_tag_i`.

## Test plan
- **Reset then idle.** Hold `rst_i` for 2 cycles -> all outputs at their reset values; `alloc_tag_o=0`.
- **In-order retire, out-of-order completion.**
  - Stimulus: allocate r1, r2, r3 (tags 0, 1, 2); write back tag 2 = 0x33, tag 0 = 0x11, tag 1 = 0x22; `commit_ack_i=1`.
  - Response: commit writes (1, 0x11), (2, 0x22), (3, 0x33) on consecutive cycles in that order.
- **Fill and wrap.**
  - Allocate 8 with no writeback -> `alloc_ready_o=0`, `count_o=8`, and a 9th request is ignored.
  - Complete and retire all 8, then allocate once -> `alloc_tag_o=0` and `count_o=1`.
- **Back-pressure and silent retire.**
  - Stimulus: a done head with `we=1` and `commit_ack_i=0` for 3 cycles.
  - Response: `commit_regfile_we_o=0` and the address/data stay stable. Raising ack then writes exactly once.
  - A `we=0` entry retires with `commit_regfile_we_o=0`.
- **Flush mid-operation.**
  - Stimulus: 5 entries, 2 of them done; assert `flush_i` together with ack, alloc and wb.
  - Response: no commit write, no allocation; the next cycle shows `empty_o=1`, `count_o=0`, `alloc_tag_o=0`.
- **Simultaneous alloc and retire at full.** Full buffer, head done, ack and alloc both high -> head retires, the alloc is rejected, and `count_o` becomes 7.

Source files
------------

// File: rtl/writeback_rob_pkg.sv
// Shared types for the writeback reorder buffer.
// REG_ADDR_SIZE / REG_DATA_WIDTH : architectural register address / data widths
// ROB_DEPTH / ROB_TAG_W          : default buffer depth and matching tag width
// rob_entry_t                    : one buffer entry {valid, done, we, waddr, data}
// rob_tag_t                      : entry tag carried from issue back to writeback
package writeback_rob_pkg;
  localparam int REG_ADDR_SIZE  = 5;
  localparam int REG_DATA_WIDTH = 32;
  localparam int ROB_DEPTH      = 8;
  localparam int ROB_TAG_W      = $clog2(ROB_DEPTH);

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic                      valid;
    logic                      done;
    logic                      we;
    logic [REG_ADDR_SIZE-1:0]  waddr;
    logic [REG_DATA_WIDTH-1:0] data;
  } rob_entry_t;
endpackage

// File: rtl/writeback_rob.sv
// In-order completion buffer in front of the commit stage.
// Allocates one entry per issued instruction (tag = tail index), accepts
// out-of-order results by tag, and retires in program order onto the
// commit register-file write port under commit_ack_i. flush_i drops all
// in-flight entries.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   alloc_valid_i/we_i/waddr_i   allocation request; alloc_ready_o = not full
//   alloc_tag_o                  tag assigned to this cycle's allocation
//   wb_valid_i/tag_i/data_i      execution result by tag
//   commit_ack_i                 commit stage takes the head this cycle
//   commit_regfile_we/waddr/wdata_o  head write port (combinational)
//   flush_i                      discard all entries
//   empty_o, count_o             occupancy
module writeback_rob #(
  parameter int DEPTH          = 8,
  parameter int TAG_W          = $clog2(DEPTH),
  parameter int REG_ADDR_SIZE  = 5,
  parameter int REG_DATA_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      alloc_valid_i,
  output logic                      alloc_ready_o,
  input  logic                      alloc_we_i,
  input  logic [REG_ADDR_SIZE-1:0]  alloc_waddr_i,
  output logic [TAG_W-1:0]          alloc_tag_o,
  input  logic                      wb_valid_i,
  input  logic [TAG_W-1:0]          wb_tag_i,
  input  logic [REG_DATA_WIDTH-1:0] wb_data_i,
  input  logic                      commit_ack_i,
  output logic                      commit_regfile_we_o,
  output logic [REG_ADDR_SIZE-1:0]  commit_regfile_waddr_o,
  output logic [REG_DATA_WIDTH-1:0] commit_regfile_wdata_o,
  input  logic                      flush_i,
  output logic                      empty_o,
  output logic [TAG_W:0]            count_o
);
  import writeback_rob_pkg::*;

  localparam logic [TAG_W:0] PTR_ONE = 1;

  rob_entry_t       ent [DEPTH];
  // MSB of each pointer is the wrap bit
  logic [TAG_W:0]   head, tail;
  logic [TAG_W-1:0] hidx, tidx;
  rob_entry_t       hent;
  logic             full, alloc_fire, wb_fire, retire;

  assign hidx = head[TAG_W-1:0];
  assign tidx = tail[TAG_W-1:0];
  assign hent = ent[hidx];

  assign full       = (hidx == tidx) && (head[TAG_W] != tail[TAG_W]);
  assign alloc_fire = alloc_valid_i && !full && !flush_i;
  assign wb_fire    = wb_valid_i && ent[wb_tag_i].valid && !flush_i;
  // done is only seen from the registered state, so no wb->commit bypass
  assign retire     = hent.valid && hent.done && commit_ack_i && !flush_i;

  assign alloc_ready_o          = !full;
  assign alloc_tag_o            = tidx;
  assign count_o                = tail - head;
  assign empty_o                = (count_o == '0);
  assign commit_regfile_we_o    = retire && hent.we;
  assign commit_regfile_waddr_o = hent.valid ? hent.waddr : '0;
  assign commit_regfile_wdata_o = hent.valid ? hent.data  : '0;

  // Index collisions cannot occur: alloc targets an invalid slot, wb needs a
  // valid one, and alloc/retire share an index only when full or empty.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
    end else begin
      if (alloc_fire) begin
        ent[tidx] <= '{valid: 1'b1, done: 1'b0, we: alloc_we_i,
                       waddr: alloc_waddr_i, data: '0};
        tail <= tail + PTR_ONE;
      end
      if (wb_fire) begin
        ent[wb_tag_i].done <= 1'b1;
        ent[wb_tag_i].data <= wb_data_i;
      end
      if (retire) begin
        ent[hidx].valid <= 1'b0;
        head <= head + PTR_ONE;
      end
    end
  end
endmodule

// File: tb/tb_writeback_rob.sv
module tb_writeback_rob;
  localparam int DEPTH = 8;
  localparam int TAG_W = 3;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic rst;
  logic alloc_valid, alloc_ready, alloc_we;
  logic [AW-1:0] alloc_waddr;
  logic [TAG_W-1:0] alloc_tag;
  logic wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [DW-1:0] wb_data;
  logic commit_ack, commit_we;
  logic [AW-1:0] commit_waddr;
  logic [DW-1:0] commit_wdata;
  logic flush, empty;
  logic [TAG_W:0] count;

  always #5 clk = ~clk;

  writeback_rob #(.DEPTH(DEPTH), .TAG_W(TAG_W), .REG_ADDR_SIZE(AW), .REG_DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready), .alloc_we_i(alloc_we),
    .alloc_waddr_i(alloc_waddr), .alloc_tag_o(alloc_tag),
    .wb_valid_i(wb_valid), .wb_tag_i(wb_tag), .wb_data_i(wb_data),
    .commit_ack_i(commit_ack), .commit_regfile_we_o(commit_we),
    .commit_regfile_waddr_o(commit_waddr), .commit_regfile_wdata_o(commit_wdata),
    .flush_i(flush), .empty_o(empty), .count_o(count)
  );

  // Reference model: in-flight instructions in program order.
  typedef struct {
    int          tag;
    bit          we;
    logic [4:0]  waddr;
    logic [31:0] data;
    bit          done;
  } ins_t;
  ins_t q[$];
  int   next_tag;

  int total = 0;
  int bad   = 0;

  // outputs observed in the last stepped cycle, and model expectations
  logic        o_ready, o_empty, o_we;
  logic [2:0]  o_tag;
  logic [3:0]  o_count;
  logic [4:0]  o_waddr;
  logic [31:0] o_wdata;
  logic        e_ready, e_empty, e_we, e_hdone;
  logic [2:0]  e_tag;
  logic [3:0]  e_count;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;

  task automatic idle_inputs();
    alloc_valid = 0; alloc_we = 0; alloc_waddr = '0;
    wb_valid = 0; wb_tag = '0; wb_data = '0;
    commit_ack = 0; flush = 0;
  endtask

  // Drives one cycle, samples outputs before the edge, advances the model.
  task automatic step(input bit a, input bit awe, input logic [4:0] awa,
                      input bit wv, input logic [2:0] wt, input logic [31:0] wd,
                      input bit ack, input bit fl);
    bit ret;
    @(negedge clk);
    alloc_valid = a; alloc_we = awe; alloc_waddr = awa;
    wb_valid = wv; wb_tag = wt; wb_data = wd;
    commit_ack = ack; flush = fl;
    #1;
    o_ready = alloc_ready; o_tag = alloc_tag; o_empty = empty; o_count = count;
    o_we = commit_we; o_waddr = commit_waddr; o_wdata = commit_wdata;
    e_ready = (q.size() < DEPTH);
    e_tag   = 3'(next_tag);
    e_count = 4'(q.size());
    e_empty = (q.size() == 0);
    e_hdone = (q.size() > 0) && q[0].done;
    ret     = e_hdone && ack && !fl;
    e_we    = ret && q[0].we;
    e_waddr = (q.size() > 0) ? q[0].waddr : 5'd0;
    e_wdata = (q.size() > 0) ? q[0].data  : 32'd0;
    @(posedge clk);
    if (fl) begin
      q.delete();
      next_tag = 0;
    end else begin
      if (wv) foreach (q[i]) if (q[i].tag == int'(wt)) begin
        q[i].done = 1;
        q[i].data = wd;
      end
      if (ret) void'(q.pop_front());
      if (a && e_ready) begin
        q.push_back('{tag: next_tag, we: awe, waddr: awa, data: 32'd0, done: 1'b0});
        next_tag = (next_tag + 1) % DEPTH;
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    idle_inputs();
    rst = 1;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst = 0;
    q.delete();
    next_tag = 0;
  endtask

  task automatic test_reset();
    do_reset(2);
    #1;
    total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", alloc_ready); end
    total++; if (alloc_tag !== 3'd0) begin bad++; $display("FAIL reset_tag got=%0d want=0", alloc_tag); end
    total++; if (empty !== 1'b1 || count !== 4'd0) begin bad++; $display("FAIL reset_occ empty=%0b count=%0d want 1/0", empty, count); end
    total++; if (commit_we !== 1'b0 || commit_waddr !== 5'd0 || commit_wdata !== 32'd0) begin
      bad++; $display("FAIL reset_commit we=%0b a=%0d d=%h want 0/0/0", commit_we, commit_waddr, commit_wdata);
    end
  endtask

  task automatic test_ooo();
    logic [4:0]  wa [3] = '{5'd1, 5'd2, 5'd3};
    logic [31:0] wdt[3] = '{32'h11, 32'h22, 32'h33};
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, wa[i], 0, 0, 0, 0, 0);
      total++; if (o_tag !== 3'(i)) begin bad++; $display("FAIL ooo_tag got=%0d want=%0d", o_tag, i); end
    end
    step(0, 0, 0, 1, 3'd2, 32'h33, 1, 0);
    total++; if (o_we !== 1'b0) begin bad++; $display("FAIL ooo_early0 we=%0b want=0", o_we); end
    step(0, 0, 0, 1, 3'd0, 32'h11, 1, 0);
    total++; if (o_we !== 1'b0) begin bad++; $display("FAIL ooo_nobypass we=%0b want=0", o_we); end
    step(0, 0, 0, 1, 3'd1, 32'h22, 1, 0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step(0, 0, 0, 0, 0, 0, 1, 0);
      total++; if (o_we !== 1'b1 || o_waddr !== wa[i] || o_wdata !== wdt[i]) begin
        bad++; $display("FAIL ooo_commit%0d we=%0b a=%0d d=%h want 1/%0d/%h", i, o_we, o_waddr, o_wdata, wa[i], wdt[i]);
      end
    end
    step(0, 0, 0, 0, 0, 0, 1, 0);
    total++; if (o_empty !== 1'b1 || o_we !== 1'b0) begin bad++; $display("FAIL ooo_drained empty=%0b we=%0b want 1/0", o_empty, o_we); end
  endtask

  task automatic test_fill_wrap();
    do_reset(1);
    for (int i = 0; i < DEPTH; i++) step(1, 1, 5'(i + 4), 0, 0, 0, 0, 0);
    step(1, 1, 5'd31, 0, 0, 0, 0, 0);
    total++; if (o_ready !== 1'b0 || o_count !== 4'd8) begin bad++; $display("FAIL full_state ready=%0b count=%0d want 0/8", o_ready, o_count); end
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 3'(i), 32'(100 + i), 0, 0);
    total++; if (o_count !== 4'd8) begin bad++; $display("FAIL full_9th_ignored count=%0d want=8", o_count); end
    // full, head done, ack and alloc together
    step(1, 1, 5'd30, 0, 0, 0, 1, 0);
    total++; if (o_ready !== 1'b0 || o_we !== 1'b1 || o_waddr !== 5'd4 || o_wdata !== 32'd100) begin
      bad++; $display("FAIL full_simul ready=%0b we=%0b a=%0d d=%0d want 0/1/4/100", o_ready, o_we, o_waddr, o_wdata);
    end
    for (int i = 1; i < DEPTH; i++) begin
      step(0, 0, 0, 0, 0, 0, 1, 0);
      if (i == 1) begin
        total++; if (o_count !== 4'd7) begin bad++; $display("FAIL full_simul_count got=%0d want=7", o_count); end
      end
      total++; if (o_we !== 1'b1 || o_waddr !== 5'(i + 4)) begin bad++; $display("FAIL fill_retire%0d we=%0b a=%0d want 1/%0d", i, o_we, o_waddr, i + 4); end
    end
    step(1, 1, 5'd9, 0, 0, 0, 0, 0);
    total++; if (o_tag !== 3'd0 || o_empty !== 1'b1) begin bad++; $display("FAIL wrap_tag tag=%0d empty=%0b want 0/1", o_tag, o_empty); end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (o_count !== 4'd1) begin bad++; $display("FAIL wrap_count got=%0d want=1", o_count); end
  endtask

  task automatic test_backpressure();
    do_reset(1);
    step(1, 1, 5'd5, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3'd0, 32'hABCD, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0);
      total++; if (o_we !== 1'b0 || o_waddr !== 5'd5 || o_wdata !== 32'hABCD) begin
        bad++; $display("FAIL bp_hold%0d we=%0b a=%0d d=%h want 0/5/abcd", i, o_we, o_waddr, o_wdata);
      end
    end
    step(0, 0, 0, 0, 0, 0, 1, 0);
    total++; if (o_we !== 1'b1) begin bad++; $display("FAIL bp_release we=%0b want=1", o_we); end
    step(1, 0, 5'd7, 0, 0, 0, 1, 0);
    total++; if (o_we !== 1'b0 || o_empty !== 1'b1) begin bad++; $display("FAIL bp_once we=%0b empty=%0b want 0/1", o_we, o_empty); end
    step(0, 0, 0, 1, 3'd1, 32'h55, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    total++; if (o_we !== 1'b0 || o_waddr !== 5'd7) begin bad++; $display("FAIL silent_retire we=%0b a=%0d want 0/7", o_we, o_waddr); end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (o_count !== 4'd0) begin bad++; $display("FAIL silent_gone count=%0d want=0", o_count); end
  endtask

  task automatic test_flush();
    do_reset(1);
    for (int i = 0; i < 5; i++) step(1, 1, 5'(i + 1), 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3'd0, 32'hA0, 0, 0);
    step(0, 0, 0, 1, 3'd1, 32'hA1, 0, 0);
    step(1, 1, 5'd20, 1, 3'd2, 32'hA2, 1, 1);
    total++; if (o_we !== 1'b0 || o_count !== 4'd5) begin bad++; $display("FAIL flush_nowrite we=%0b count=%0d want 0/5", o_we, o_count); end
    step(0, 0, 0, 0, 0, 0, 1, 0);
    total++; if (o_empty !== 1'b1 || o_count !== 4'd0 || o_tag !== 3'd0 || o_we !== 1'b0 || o_waddr !== 5'd0) begin
      bad++; $display("FAIL flush_after empty=%0b count=%0d tag=%0d we=%0b a=%0d want 1/0/0/0/0", o_empty, o_count, o_tag, o_we, o_waddr);
    end
  endtask

  task automatic test_random();
    bit a, awe, wv, ack, fl;
    logic [2:0] wt;
    do_reset(1);
    for (int n = 0; n < 600; n++) begin
      a   = ($urandom_range(0, 99) < 60);
      awe = $urandom_range(0, 1);
      wv  = ($urandom_range(0, 99) < 60);
      // mostly target in-flight entries, sometimes a random (possibly idle) tag
      if (q.size() > 0 && $urandom_range(0, 3) != 0) wt = 3'(q[$urandom_range(0, q.size() - 1)].tag);
      else wt = 3'($urandom_range(0, 7));
      ack = ($urandom_range(0, 99) < 55);
      fl  = ($urandom_range(0, 99) < 3);
      step(a, awe, 5'($urandom), wv, wt, $urandom, ack, fl);
      total++; if (o_ready !== e_ready || o_tag !== e_tag) begin bad++; $display("FAIL rnd_alloc n=%0d ready=%0b tag=%0d want %0b/%0d", n, o_ready, o_tag, e_ready, e_tag); end
      total++; if (o_count !== e_count || o_empty !== e_empty) begin bad++; $display("FAIL rnd_occ n=%0d count=%0d empty=%0b want %0d/%0b", n, o_count, o_empty, e_count, e_empty); end
      total++; if (o_we !== e_we || o_waddr !== e_waddr) begin bad++; $display("FAIL rnd_commit n=%0d we=%0b a=%0d want %0b/%0d", n, o_we, o_waddr, e_we, e_waddr); end
      if (e_hdone || e_empty) begin
        total++; if (o_wdata !== e_wdata) begin bad++; $display("FAIL rnd_wdata n=%0d got=%h want=%h", n, o_wdata, e_wdata); end
      end
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    next_tag = 0;
    test_reset();
    test_ooo();
    test_fill_wrap();
    test_backpressure();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
